// File: rtl/start_screen_renderer.sv
// rtl/start_screen_renderer.sv - bitmap start-screen line renderer with blink control
//
// Purpose: fetches one bitmap ROM row per scan line and streams it out as
// scaled pixels. Each bitmap cell covers 2^SCALE_LOG2 x 2^SCALE_LOG2 screen
// pixels. An optional blink blanks the whole image on alternating groups of
// BLINK_FRAMES frames.
//
// Ports:
//   Clk          system clock, rising edge
//   Reset_n      synchronous active-low reset
//   frame_start  one-cycle pulse per frame (drives the blink counter)
//   line_start   one-cycle pulse per scan line, DrawY valid alongside
//   DrawY        scan line index
//   pixel_en     one-cycle strobe per visible pixel, left to right
//   blink_en     1 = blinking enabled, 0 = always visible
//   rom_addr     bitmap ROM row address
//   rom_data     combinational ROM word, bit COLS-1 = leftmost cell
//   pixel_on     registered pixel value for the last pixel_en
//   busy         high while fetching or streaming a line

module start_screen_renderer #(
    parameter int COLS         = 40,
    parameter int ROWS         = 30,
    parameter int SCALE_LOG2   = 4,
    parameter int BLINK_FRAMES = 30
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_start,
    input  logic            line_start,
    input  logic [9:0]      DrawY,
    input  logic            pixel_en,
    input  logic            blink_en,
    output logic [5:0]      rom_addr,
    input  logic [COLS-1:0] rom_data,
    output logic            pixel_on,
    output logic            busy
);

    localparam int COL_W = $clog2(COLS + 1);
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t                state;
    logic [COLS-1:0]       shift_reg;
    logic [COL_W-1:0]      col_cnt;
    logic [SCALE_LOG2-1:0] sub_cnt;
    logic [FRM_W-1:0]      frame_cnt;
    logic                  blank_phase;

    logic [9:0]            row_calc;
    logic                  row_ok;
    logic                  visible;

    assign row_calc = DrawY >> SCALE_LOG2;
    assign row_ok   = (row_calc < 10'(ROWS));
    assign visible  = ~(blink_en & blank_phase);
    assign busy     = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            rom_addr    <= '0;
            shift_reg   <= '0;
            col_cnt     <= '0;
            sub_cnt     <= '0;
            pixel_on    <= 1'b0;
            frame_cnt   <= '0;
            blank_phase <= 1'b0;
        end else begin
            // Blink timing runs independently of the line machine and of blink_en.
            if (frame_start) begin
                if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blank_phase <= ~blank_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            if (line_start) begin
                // A new line always wins: abort whatever is in flight.
                if (pixel_en) begin
                    pixel_on <= 1'b0;
                end
                col_cnt <= '0;
                sub_cnt <= '0;
                if (row_ok) begin
                    rom_addr <= row_calc[5:0];
                    state    <= FETCH;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (pixel_en) begin
                            pixel_on <= 1'b0;
                        end
                    end
                    FETCH: begin
                        shift_reg <= rom_data;
                        state     <= STREAM;
                        if (pixel_en) begin
                            pixel_on <= 1'b0;
                        end
                    end
                    STREAM: begin
                        if (pixel_en) begin
                            pixel_on <= shift_reg[COLS-1] & visible;
                            sub_cnt  <= sub_cnt + 1'b1;
                            // Last sub-pixel of a cell: move to the next cell.
                            if (sub_cnt == {SCALE_LOG2{1'b1}}) begin
                                shift_reg <= {shift_reg[COLS-2:0], 1'b0};
                                col_cnt   <= col_cnt + 1'b1;
                                if (col_cnt == COL_W'(COLS - 1)) begin
                                    state <= IDLE;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_start_screen_renderer.sv
// tb/tb_start_screen_renderer.sv - self-checking bench for start_screen_renderer

module tb_start_screen_renderer;

    localparam int COLS  = 40;
    localparam int ROWS  = 30;
    localparam int SCALE = 16;
    localparam int BF    = 30;
    localparam int NPIX  = COLS * SCALE;

    logic            Clk;
    logic            Reset_n;
    logic            frame_start;
    logic            line_start;
    logic [9:0]      DrawY;
    logic            pixel_en;
    logic            blink_en;
    logic [5:0]      rom_addr;
    logic [COLS-1:0] rom_data;
    logic            pixel_on;
    logic            busy;

    logic [COLS-1:0] rom [0:ROWS-1];

    int checks;
    int errors;
    bit started;

    // Behavioural model state
    bit        m_active;
    bit        m_fetch;
    int        m_row;
    int        m_pix;
    bit        m_on;
    int        m_frames;
    logic [5:0] m_addr;

    bit cap [0:NPIX+15];

    start_screen_renderer dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .line_start  (line_start),
        .DrawY       (DrawY),
        .pixel_en    (pixel_en),
        .blink_en    (blink_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_on    (pixel_on),
        .busy        (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always_comb begin
        rom_data = '0;
        if (rom_addr < 6'(ROWS)) rom_data = rom[rom_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a line is a fetch cycle followed by NPIX pixels; pixel k shows
    // bitmap cell k/SCALE of the selected row, blanked on odd blink groups.
    always @(posedge Clk) begin
        bit vis;
        int r;
        if (!Reset_n) begin
            m_active = 0; m_fetch = 0; m_pix = 0; m_on = 0;
            m_frames = 0; m_addr = 0;
        end else begin
            vis = !(blink_en && (((m_frames / BF) % 2) == 1));
            if (frame_start) m_frames++;
            if (line_start) begin
                r = int'(DrawY) / SCALE;
                if (pixel_en) m_on = 0;
                if (r < ROWS) begin
                    m_active = 1; m_fetch = 1; m_row = r; m_pix = 0;
                    m_addr = 6'(r);
                end else begin
                    m_active = 0; m_fetch = 0;
                end
            end else begin
                if (pixel_en) begin
                    if (m_active && !m_fetch) begin
                        m_on = rom[m_row][COLS - 1 - m_pix / SCALE] && vis;
                        m_pix++;
                        if (m_pix == NPIX) m_active = 0;
                    end else begin
                        m_on = 0;
                    end
                end
                m_fetch = 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (started) begin
            chk("pixel_on", 64'(pixel_on), 64'(m_on));
            chk("busy", 64'(busy), 64'(m_active));
            chk("rom_addr", 64'(rom_addr), 64'(m_addr));
        end
    end

    task automatic cyc(input bit ls, input bit pe, input bit fs);
        line_start  = ls;
        pixel_en    = pe;
        frame_start = fs;
        @(posedge Clk);
        @(negedge Clk);
        line_start  = 1'b0;
        pixel_en    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1);
            cyc(0, 0, 0);
        end
    endtask

    // Starts a line, waits out the fetch cycle, then streams npix pixels.
    task automatic run_line(input logic [9:0] dy, input int npix);
        DrawY = dy;
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        for (int i = 0; i < npix; i++) begin
            cyc(0, 1, 0);
            cap[i] = pixel_on;
        end
    endtask

    task automatic check_row13(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < 128; i++) begin
            if (cap[i] != ((i >= 16) && (i < 96))) bad++;
        end
        chk({tag, "_pattern_errs"}, 64'(bad), 64'd0);
    endtask

    task automatic count_ones(input string tag, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(cap[i]);
        chk({tag, "_ones"}, 64'(ones), 64'd0);
    endtask

    initial begin
        checks = 0; errors = 0; started = 0;
        Reset_n = 1'b0; frame_start = 0; line_start = 0; pixel_en = 0;
        blink_en = 0; DrawY = '0;
        for (int i = 0; i < ROWS; i++) rom[i] = {8'($urandom), $urandom};
        rom[0]  = '0;
        rom[13] = 40'b0111110011111110000100000011111001111111;
        rom[14] = 40'hC3A55A3C81;

        @(negedge Clk);
        cyc(1, 1, 1);
        cyc(0, 1, 0);
        chk("reset_pixel_on", 64'(pixel_on), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_rom_addr", 64'(rom_addr), 64'd0);
        Reset_n = 1'b1;
        started = 1;

        // Row 13 pattern
        DrawY = 10'd208;
        cyc(1, 0, 0);
        chk("fetch_busy", 64'(busy), 64'd1);
        chk("fetch_rom_addr", 64'(rom_addr), 64'd13);
        cyc(0, 1, 0);
        chk("fetch_pixel_gated", 64'(pixel_on), 64'd0);
        for (int i = 0; i < NPIX; i++) begin
            cyc(0, 1, 0);
            cap[i] = pixel_on;
            if (i == NPIX - 2) chk("busy_before_last", 64'(busy), 64'd1);
        end
        check_row13("row13");
        chk("busy_after_639", 64'(busy), 64'd0);

        // Blank row, overrun into IDLE
        run_line(10'd0, 650);
        count_ones("row0", 650);
        chk("row0_busy_end", 64'(busy), 64'd0);

        // Off-bitmap line
        run_line(10'd480, 20);
        count_ones("row480", 20);
        chk("row480_busy", 64'(busy), 64'd0);
        chk("row480_addr_hold", 64'(rom_addr), 64'd0);

        // Blink
        blink_en = 1'b1;
        frames(BF);
        run_line(10'd208, 200);
        count_ones("blank", 200);
        frames(BF);
        run_line(10'd208, 128);
        check_row13("blink_back");
        frames(BF);
        blink_en = 1'b0;
        run_line(10'd208, 128);
        check_row13("blink_off");
        frames(BF);

        // Reset mid-stream
        run_line(10'd208, 100);
        Reset_n = 1'b0;
        cyc(0, 1, 0);
        Reset_n = 1'b1;
        chk("mid_reset_pixel_on", 64'(pixel_on), 64'd0);
        chk("mid_reset_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 20; i++) begin
            cyc(0, 1, 0);
            cap[i] = pixel_on;
        end
        count_ones("post_reset", 20);
        run_line(10'd209, NPIX);
        check_row13("row209");

        // Line restart mid-stream
        run_line(10'd208, 300);
        DrawY = 10'd224;
        cyc(1, 1, 0);
        chk("restart_pixel_on", 64'(pixel_on), 64'd0);
        chk("restart_rom_addr", 64'(rom_addr), 64'd14);
        cyc(0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 0);
            cap[i] = pixel_on;
        end
        chk("restart_col0", 64'(cap[0]), 64'd1);
        chk("restart_col1", 64'(cap[16]), 64'd1);
        for (int i = 0; i < NPIX; i++) cyc(0, 1, 0);
        chk("restart_done_busy", 64'(busy), 64'd0);

        started = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
